l1_mmu_arbiter: RTL and testbench
=================================

L1_MMU_ARBITER -- requirements
Module: l1_mmu_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1023: GRANT-state cycle count (range 1..65535) at which a stalled MMU transaction is force-completed.
REQ-002 SHALL have sys_clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have rst  in  1  reset; synchronous and active-high.
REQ-004 SHALL have i_req, i_req_read, i_req_write  in  1 each  instruction-L1 request level, read type, write type.
REQ-005 SHALL have i_req_addr, i_write_data  in  32 each  instruction-L1 word address and write data.
REQ-006 SHALL have i_read_done, i_write_done, i_volatile  out  1 each, and i_read_data  out  32: completion returned to instruction L1.
REQ-007 SHALL have d_req, d_req_read, d_req_write, d_req_addr, d_write_data (in) and d_read_done, d_write_done, d_volatile, d_read_data (out): same widths/meaning for data L1.
REQ-008 SHALL have mmu_req, mmu_req_read, mmu_req_write  out  1 each, and mmu_addr, mmu_write_data  out  32: shared MMU request port, all registered.
REQ-009 SHALL have mmu_read_done, mmu_write_done, mmu_volatile  in  1 each, and mmu_read_data  in  32: MMU completion.
REQ-010 SHALL have owner  out  1 (0 = I, 1 = D, valid in GRANT states) and timeout_err  out  1 (sticky).

Function
REQ-011 SHALL implement states IDLE, GRANT_I, GRANT_D, RELEASE.
REQ-012 In IDLE, SHALL grant the sole requester; if i_req and d_req are both high, SHALL grant the side not recorded in last_owner (round-robin).
REQ-013 On grant, SHALL latch that requester's addr, write data and type into the mmu_* registers; mmu_req high the cycle after the request is sampled in IDLE.
REQ-014 SHALL drive mmu_req_read = latched read; mmu_req_write = latched write AND NOT latched read (read wins if both set); a request with neither type asserted SHALL NOT be granted.
REQ-015 In GRANT_x, mmu_read_done/mmu_write_done, mmu_volatile and mmu_read_data SHALL route combinationally, same cycle, to the owner only; the non-owner sees done = 0, volatile = 0, data = 0.
REQ-016 Either done input SHALL complete the transaction: next state RELEASE, mmu_* cleared to 0, last_owner := owner.
REQ-017 The owner dropping its req mid-transaction SHALL NOT abort; the transaction runs to MMU done, which is still forwarded.
REQ-018 RELEASE SHALL last exactly one cycle with mmu_req = 0, then IDLE; earliest back-to-back: done in cycle M, next mmu_req in cycle M+3.
REQ-019 A 16-bit timer SHALL clear on grant and increment each GRANT cycle with no done.
REQ-020 When timer reaches TIMEOUT_CYCLES with no done in that cycle, SHALL pulse the owner's done matching the latched type for one cycle with read_data = 0, volatile = 1, set timeout_err, and go to RELEASE.
REQ-021 A real done in the same cycle as timeout SHALL take precedence: normal completion, timeout_err unchanged.
REQ-022 Requests arriving during GRANT or RELEASE SHALL wait (level-held) and be arbitrated in the next IDLE.

Reset
REQ-023 rst high at a rising edge SHALL force state IDLE, all mmu_* = 0, owner = 0, last_owner = 1 (I wins the first tie), timer = 0, timeout_err = 0.
REQ-024 Reset mid-transaction SHALL abandon it with no done pulse to either requester.
REQ-025 All i_*/d_* done outputs SHALL be 0 while in reset and in IDLE/RELEASE.

Verification
REQ-026 I-only read, addr 0x0000_1000, MMU read_done + data 0x1234_5678 after 5 cycles -> i_read_done pulse with i_read_data 0x1234_5678; d_read_done stays 0.
REQ-027 i_req and d_req raised same cycle after reset -> I granted first (mmu_addr = I addr); after completion and RELEASE, D granted; next tie grants I.
REQ-028 D write, addr 0x0000_2004, data 0xCAFE_BABE -> mmu_req_write = 1, mmu_write_data 0xCAFE_BABE; write_done -> d_write_done same cycle; mmu_req low next cycle.
REQ-029 TIMEOUT_CYCLES = 8, MMU silent -> after 8 GRANT cycles owner gets done, data 0, volatile 1; timeout_err = 1 and stays 1 until rst.
REQ-030 rst asserted mid-GRANT_D -> next cycle IDLE, mmu_req = 0, no done pulse; a held d_req is re-granted after rst falls.

Source files
------------

// File: rtl/l1_mmu_arbiter_if.sv
// rtl/l1_mmu_arbiter_if.sv - instruction/data L1 request ports and shared MMU port
interface l1_mmu_arbiter_if;
    logic        i_req;
    logic        i_req_read;
    logic        i_req_write;
    logic [31:0] i_req_addr;
    logic [31:0] i_write_data;
    logic        i_read_done;
    logic        i_write_done;
    logic        i_volatile;
    logic [31:0] i_read_data;

    logic        d_req;
    logic        d_req_read;
    logic        d_req_write;
    logic [31:0] d_req_addr;
    logic [31:0] d_write_data;
    logic        d_read_done;
    logic        d_write_done;
    logic        d_volatile;
    logic [31:0] d_read_data;

    logic        mmu_req;
    logic        mmu_req_read;
    logic        mmu_req_write;
    logic [31:0] mmu_addr;
    logic [31:0] mmu_write_data;
    logic        mmu_read_done;
    logic        mmu_write_done;
    logic        mmu_volatile;
    logic [31:0] mmu_read_data;

    logic        owner;
    logic        timeout_err;

    modport master (
        input  i_req, i_req_read, i_req_write, i_req_addr, i_write_data,
        output i_read_done, i_write_done, i_volatile, i_read_data,
        input  d_req, d_req_read, d_req_write, d_req_addr, d_write_data,
        output d_read_done, d_write_done, d_volatile, d_read_data,
        output mmu_req, mmu_req_read, mmu_req_write, mmu_addr, mmu_write_data,
        input  mmu_read_done, mmu_write_done, mmu_volatile, mmu_read_data,
        output owner, timeout_err
    );

    modport slave (
        output i_req, i_req_read, i_req_write, i_req_addr, i_write_data,
        input  i_read_done, i_write_done, i_volatile, i_read_data,
        output d_req, d_req_read, d_req_write, d_req_addr, d_write_data,
        input  d_read_done, d_write_done, d_volatile, d_read_data,
        input  mmu_req, mmu_req_read, mmu_req_write, mmu_addr, mmu_write_data,
        output mmu_read_done, mmu_write_done, mmu_volatile, mmu_read_data,
        input  owner, timeout_err
    );
endinterface

// File: rtl/l1_mmu_arbiter.sv
// rtl/l1_mmu_arbiter.sv - round-robin arbiter of I/D L1 requests onto one MMU port with stall timeout
module l1_mmu_arbiter #(
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic              sys_clk,
    input  logic              rst,
    l1_mmu_arbiter_if.master  bus
);
    typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, RELEASE} state_t;

    localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);

    state_t      state_q;
    logic        owner_q;
    logic        last_owner_q;
    logic        req_q;
    logic        rd_q;
    logic        wr_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [15:0] timer_q;
    logic        err_q;

    logic        i_valid;
    logic        d_valid;
    logic        pick_d;
    logic        in_grant;
    logic        mmu_done;
    logic        timeout;

    // A request with no type asserted is invisible to arbitration.
    assign i_valid  = bus.i_req & (bus.i_req_read | bus.i_req_write);
    assign d_valid  = bus.d_req & (bus.d_req_read | bus.d_req_write);
    assign pick_d   = d_valid & (~i_valid | ~last_owner_q);
    assign in_grant = (state_q == GRANT_I) || (state_q == GRANT_D);
    assign mmu_done = bus.mmu_read_done | bus.mmu_write_done;
    assign timeout  = in_grant & ~mmu_done & (timer_q == TIMEOUT_LIM);

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            req_q        <= 1'b0;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            timer_q      <= 16'd0;
            err_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_valid || d_valid) begin
                        state_q <= pick_d ? GRANT_D : GRANT_I;
                        owner_q <= pick_d;
                        req_q   <= 1'b1;
                        timer_q <= 16'd0;
                        if (pick_d) begin
                            addr_q  <= bus.d_req_addr;
                            wdata_q <= bus.d_write_data;
                            rd_q    <= bus.d_req_read;
                            wr_q    <= bus.d_req_write & ~bus.d_req_read;
                        end else begin
                            addr_q  <= bus.i_req_addr;
                            wdata_q <= bus.i_write_data;
                            rd_q    <= bus.i_req_read;
                            wr_q    <= bus.i_req_write & ~bus.i_req_read;
                        end
                    end
                end
                GRANT_I, GRANT_D: begin
                    // The owner's req is deliberately ignored here: only MMU done or timeout ends it.
                    if (mmu_done || timeout) begin
                        state_q      <= RELEASE;
                        last_owner_q <= owner_q;
                        req_q        <= 1'b0;
                        rd_q         <= 1'b0;
                        wr_q         <= 1'b0;
                        addr_q       <= 32'd0;
                        wdata_q      <= 32'd0;
                        if (timeout) begin
                            err_q <= 1'b1;
                        end
                    end else begin
                        timer_q <= timer_q + 16'd1;
                    end
                end
                RELEASE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    logic        rd_done;
    logic        wr_done;
    logic        vol;
    logic [31:0] rdata;

    always_comb begin
        rd_done = 1'b0;
        wr_done = 1'b0;
        vol     = 1'b0;
        rdata   = 32'd0;
        if (in_grant && !rst) begin
            rd_done = bus.mmu_read_done | (timeout & rd_q);
            wr_done = bus.mmu_write_done | (timeout & wr_q);
            vol     = bus.mmu_volatile | timeout;
            rdata   = timeout ? 32'd0 : bus.mmu_read_data;
        end
    end

    assign bus.i_read_done    = rd_done & ~owner_q;
    assign bus.i_write_done   = wr_done & ~owner_q;
    assign bus.i_volatile     = vol & ~owner_q;
    assign bus.i_read_data    = owner_q ? 32'd0 : rdata;
    assign bus.d_read_done    = rd_done & owner_q;
    assign bus.d_write_done   = wr_done & owner_q;
    assign bus.d_volatile     = vol & owner_q;
    assign bus.d_read_data    = owner_q ? rdata : 32'd0;

    assign bus.mmu_req        = req_q;
    assign bus.mmu_req_read   = rd_q;
    assign bus.mmu_req_write  = wr_q;
    assign bus.mmu_addr       = addr_q;
    assign bus.mmu_write_data = wdata_q;
    assign bus.owner          = owner_q;
    assign bus.timeout_err    = err_q;
endmodule

// File: tb/tb_l1_mmu_arbiter.sv
// tb/tb_l1_mmu_arbiter.sv - randomized self-checking bench for l1_mmu_arbiter
module tb_l1_mmu_arbiter;
    localparam int T = 8;

    logic sys_clk = 1'b0;
    logic rst     = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   model_last = 1;
    bit   model_err  = 1'b0;

    l1_mmu_arbiter_if bus();

    l1_mmu_arbiter #(.TIMEOUT_CYCLES(T)) dut (
        .sys_clk (sys_clk),
        .rst     (rst),
        .bus     (bus)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic mmu_quiet();
        bus.mmu_read_done  = 1'b0;
        bus.mmu_write_done = 1'b0;
        bus.mmu_volatile   = 1'b0;
        bus.mmu_read_data  = 32'd0;
    endtask

    // lat = silent GRANT cycles before the MMU answers; lat > T means it never does.
    task automatic txn(input bit i_on, input bit i_rd, input bit i_wr, input logic [31:0] i_a, input logic [31:0] i_wd,
                       input bit d_on, input bit d_rd, input bit d_wr, input logic [31:0] d_a, input logic [31:0] d_wd,
                       input int lat, input logic [31:0] done_data, input bit drop);
        int g, fire;
        bit iv, dv, e_rd, e_wr, tmo, comp, drv_vol;
        logic [31:0] e_a, e_wd, drv_data, x_data;
        logic [2:0] x_flags;
        @(negedge sys_clk);
        rst = 1'b0;
        mmu_quiet();
        bus.i_req = i_on; bus.i_req_read = i_rd; bus.i_req_write = i_wr; bus.i_req_addr = i_a; bus.i_write_data = i_wd;
        bus.d_req = d_on; bus.d_req_read = d_rd; bus.d_req_write = d_wr; bus.d_req_addr = d_a; bus.d_write_data = d_wd;
        #1;
        check_eq("idle_req", bus.mmu_req, 0);
        check_eq("idle_err", bus.timeout_err, model_err);
        check_eq("idle_done", {bus.i_read_done, bus.i_write_done, bus.d_read_done, bus.d_write_done}, 0);
        iv = i_on && (i_rd || i_wr);
        dv = d_on && (d_rd || d_wr);
        if (!iv && !dv) g = -1;
        else if (iv && dv) g = (model_last == 1) ? 0 : 1;
        else g = dv ? 1 : 0;
        if (g < 0) begin
            @(negedge sys_clk);
            #1;
            check_eq("no_grant", bus.mmu_req, 0);
            bus.i_req = 1'b0; bus.d_req = 1'b0;
            return;
        end
        e_rd = (g == 1) ? d_rd : i_rd;
        e_wr = ((g == 1) ? d_wr : i_wr) && !e_rd;
        e_a  = (g == 1) ? d_a : i_a;
        e_wd = (g == 1) ? d_wd : i_wd;
        tmo  = (lat > T);
        fire = tmo ? T + 1 : lat + 1;
        @(negedge sys_clk);
        #1;
        check_eq("grant_req", bus.mmu_req, 1);
        check_eq("grant_owner", bus.owner, g[0]);
        check_eq("grant_addr", bus.mmu_addr, e_a);
        check_eq("grant_wdata", bus.mmu_write_data, e_wd);
        check_eq("grant_type", {bus.mmu_req_read, bus.mmu_req_write}, {e_rd, e_wr});
        if (drop) begin
            if (g == 1) bus.d_req = 1'b0; else bus.i_req = 1'b0;
        end
        for (int k = 1; k <= fire; k++) begin
            if (k > 1) @(negedge sys_clk);
            comp     = (k == fire);
            drv_data = (comp && !tmo) ? done_data : $urandom;
            drv_vol  = 1'($urandom_range(0, 1));
            bus.mmu_read_data  = drv_data;
            bus.mmu_volatile   = drv_vol;
            bus.mmu_read_done  = comp && !tmo && e_rd;
            bus.mmu_write_done = comp && !tmo && e_wr;
            #1;
            x_flags = {comp && e_rd, comp && e_wr, (comp && tmo) ? 1'b1 : drv_vol};
            x_data  = (comp && tmo) ? 32'd0 : drv_data;
            if (g == 1) begin
                check_eq("d_flags", {bus.d_read_done, bus.d_write_done, bus.d_volatile}, x_flags);
                check_eq("d_data", bus.d_read_data, x_data);
                check_eq("i_quiet", {bus.i_read_done, bus.i_write_done, bus.i_volatile, bus.i_read_data}, 0);
            end else begin
                check_eq("i_flags", {bus.i_read_done, bus.i_write_done, bus.i_volatile}, x_flags);
                check_eq("i_data", bus.i_read_data, x_data);
                check_eq("d_quiet", {bus.d_read_done, bus.d_write_done, bus.d_volatile, bus.d_read_data}, 0);
            end
        end
        if (tmo) model_err = 1'b1;
        model_last = g;
        @(negedge sys_clk);
        mmu_quiet();
        bus.i_req = 1'b0; bus.d_req = 1'b0;
        #1;
        check_eq("rel_mmu", {bus.mmu_req, bus.mmu_req_read, bus.mmu_req_write, bus.mmu_addr, bus.mmu_write_data}, 0);
        check_eq("rel_done", {bus.i_read_done, bus.i_write_done, bus.d_read_done, bus.d_write_done}, 0);
        check_eq("rel_err", bus.timeout_err, model_err);
    endtask

    initial begin
        mmu_quiet();
        bus.i_req = 0; bus.i_req_read = 0; bus.i_req_write = 0; bus.i_req_addr = 0; bus.i_write_data = 0;
        bus.d_req = 0; bus.d_req_read = 0; bus.d_req_write = 0; bus.d_req_addr = 0; bus.d_write_data = 0;
        repeat (2) @(negedge sys_clk);
        #1;
        check_eq("rst_mmu", {bus.mmu_req, bus.mmu_req_read, bus.mmu_req_write, bus.mmu_addr, bus.mmu_write_data}, 0);
        check_eq("rst_owner_err", {bus.owner, bus.timeout_err}, 0);

        // Tie sequence after reset: I, then D, then I again.
        for (int n = 0; n < 3; n++)
            txn(1, 1, 0, 32'h0000_0100, 0, 1, 1, 0, 32'h0000_0200, 0, 1, 32'h0000_00A0 + n, 0);
        txn(1, 1, 0, 32'h0000_1000, 0, 0, 0, 0, 0, 0, 5, 32'h1234_5678, 0);
        txn(0, 0, 0, 0, 0, 1, 0, 1, 32'h0000_2004, 32'hCAFE_BABE, 0, 0, 0);
        txn(1, 1, 1, 32'h0000_3000, 32'h5555_AAAA, 0, 0, 0, 0, 0, 2, 32'h0BAD_F00D, 1);
        txn(1, 0, 0, 32'h0000_4000, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        txn(0, 0, 0, 0, 0, 1, 1, 0, 32'h0000_5000, 0, T, 32'h7777_0001, 0);
        txn(0, 0, 0, 0, 0, 1, 0, 1, 32'h0000_6000, 32'h1, 20, 0, 0);
        for (int n = 0; n < 40; n++)
            txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom,
                int'($urandom_range(0, T + 2)), $urandom, 1'($urandom_range(0, 1)));

        // Reset in the middle of a D read, with the MMU answering during reset.
        @(negedge sys_clk);
        bus.d_req = 1; bus.d_req_read = 1; bus.d_req_write = 0; bus.d_req_addr = 32'h0000_7000;
        bus.i_req = 0;
        @(negedge sys_clk);
        #1;
        check_eq("pre_rst_grant", {bus.mmu_req, bus.owner}, 2'b11);
        @(negedge sys_clk);
        rst = 1'b1;
        bus.mmu_read_done = 1'b1; bus.mmu_read_data = 32'hDEAD_BEEF;
        #1;
        check_eq("rst_no_done", {bus.i_read_done, bus.i_write_done, bus.d_read_done, bus.d_write_done, bus.d_read_data}, 0);
        model_last = 1;
        model_err  = 1'b0;
        txn(0, 0, 0, 0, 0, 1, 1, 0, 32'h0000_7000, 0, 3, 32'h2468_ACE0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
